// File: rtl/fetch_pkg.sv
// Shared types and defaults for the IF stage: FSM state encoding, reset PC,
// bubble instruction and IF/ID field width.
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [XLEN-1:0] NOP_DEFAULT      = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } fetch_state_e;

  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a fetched instruction, insert a bubble, or hold.
// With FETCH_ADEL_CHK_EN it also carries the address-error flag.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP = NOP_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            bubble,
  input  logic [XLEN-1:0] ir_in,
  input  logic [XLEN-1:0] pc_in,
`ifdef FETCH_ADEL_CHK_EN
  input  logic            adel_in,
  output logic            adel_out,
`endif
  output logic [XLEN-1:0] ir_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc4_out,
  output logic            valid_out
);

  // Bubbles clear the instruction but keep the PC fields for the next-PC logic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_out    <= NOP;
      pc_out    <= '0;
      pc4_out   <= XLEN'(4);
      valid_out <= 1'b0;
`ifdef FETCH_ADEL_CHK_EN
      adel_out  <= 1'b0;
`endif
    end else if (load) begin
      ir_out    <= ir_in;
      pc_out    <= pc_in;
      pc4_out   <= pc_plus4(pc_in);
      valid_out <= 1'b1;
`ifdef FETCH_ADEL_CHK_EN
      adel_out  <= adel_in;
`endif
    end else if (bubble) begin
      ir_out    <= NOP;
      valid_out <= 1'b0;
`ifdef FETCH_ADEL_CHK_EN
      adel_out  <= 1'b0;
`endif
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage with branch delay slot: fetch PC, single-outstanding imem handshake,
// hold buffer and pending redirect. Optional misaligned-fetch check: FETCH_ADEL_CHK_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP      = NOP_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] target_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] ir_d_o,
  output logic [XLEN-1:0] pc_d_o,
  output logic [XLEN-1:0] pc4_d_o,
`ifdef FETCH_ADEL_CHK_EN
  output logic            adel_d_o,
`endif
  output logic            valid_d_o
);

  fetch_state_e    state, state_n;
  logic [XLEN-1:0] fetch_pc, req_addr, pend_tgt, hold_ir, hold_pc;
  logic            pend;
  logic            accept, redir_now, redir_pend;
  logic [XLEN-1:0] eff_pc, tgt_eff, next_seq, rsp_ir, ld_ir, ld_pc;
  logic            misaligned, issue, grant, rsp_valid;
  logic            load, bubble, to_hold;
`ifdef FETCH_ADEL_CHK_EN
  logic            fake_rsp, hold_adel, ld_adel, rsp_adel;
`endif

  // A redirect either retargets the fetch issued this very cycle (delay slot
  // already granted) or waits for the delay-slot grant via pend/pend_tgt.
  assign accept     = redirect_i & valid_d_o & ~stall_i;
  assign redir_now  = accept & (fetch_pc == pc_plus4(pc4_d_o));
  assign redir_pend = accept & (fetch_pc == pc4_d_o);
  assign eff_pc     = redir_now ? target_i : fetch_pc;
  assign tgt_eff    = redir_pend ? target_i : pend_tgt;
  assign next_seq   = (pend | redir_pend) ? tgt_eff : pc_plus4(eff_pc);

`ifdef FETCH_ADEL_CHK_EN
  // A misaligned fetch is "granted" internally and answered one cycle later.
  assign misaligned = |eff_pc[1:0];
  assign rsp_valid  = fake_rsp | imem_rvalid_i;
  assign rsp_ir     = fake_rsp ? NOP : imem_rdata_i;
  assign rsp_adel   = fake_rsp;
`else
  assign misaligned = 1'b0;
  assign rsp_valid  = imem_rvalid_i;
  assign rsp_ir     = imem_rdata_i;
`endif

  assign issue       = (state == S_REQ) | ((state == S_WAIT) & rsp_valid & ~stall_i);
  assign imem_req_o  = issue & ~misaligned;
  assign grant       = issue & (misaligned | imem_gnt_i);
  assign imem_addr_o = eff_pc;

  always_comb begin
    state_n = state;
    load    = 1'b0;
    bubble  = 1'b0;
    to_hold = 1'b0;
    ld_ir   = rsp_ir;
    ld_pc   = req_addr;
`ifdef FETCH_ADEL_CHK_EN
    ld_adel = rsp_adel;
`endif
    unique case (state)
      S_REQ: begin
        bubble = ~stall_i;
        if (grant) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (rsp_valid) begin
          if (stall_i) begin
            to_hold = 1'b1;
            state_n = S_HOLD;
          end else begin
            load    = 1'b1;
            state_n = grant ? S_WAIT : S_REQ;
          end
        end else begin
          bubble = ~stall_i;
        end
      end
      S_HOLD: begin
        ld_ir = hold_ir;
        ld_pc = hold_pc;
`ifdef FETCH_ADEL_CHK_EN
        ld_adel = hold_adel;
`endif
        load  = ~stall_i;
        if (!stall_i) state_n = S_REQ;
      end
      default: state_n = S_REQ;
    endcase
  end

  // Reset drops any outstanding request; a late rvalid then lands in S_REQ and is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_REQ;
      fetch_pc  <= RESET_PC;
      req_addr  <= '0;
      pend      <= 1'b0;
      pend_tgt  <= '0;
      hold_ir   <= NOP;
      hold_pc   <= '0;
`ifdef FETCH_ADEL_CHK_EN
      fake_rsp  <= 1'b0;
      hold_adel <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (grant) begin
        fetch_pc <= next_seq;
        req_addr <= eff_pc;
        pend     <= 1'b0;
`ifdef FETCH_ADEL_CHK_EN
        fake_rsp <= misaligned;
`endif
      end else begin
        fetch_pc <= eff_pc;
        if (redir_pend) begin
          pend     <= 1'b1;
          pend_tgt <= target_i;
        end
      end
      if (to_hold) begin
        hold_ir <= rsp_ir;
        hold_pc <= req_addr;
`ifdef FETCH_ADEL_CHK_EN
        hold_adel <= rsp_adel;
`endif
      end
    end
  end

  if_id_reg #(
    .NOP(NOP)
  ) u_if_id (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .bubble   (bubble),
    .ir_in    (ld_ir),
    .pc_in    (ld_pc),
`ifdef FETCH_ADEL_CHK_EN
    .adel_in  (ld_adel),
    .adel_out (adel_d_o),
`endif
    .ir_out   (ir_d_o),
    .pc_out   (pc_d_o),
    .pc4_out  (pc4_d_o),
    .valid_out(valid_d_o)
  );

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage MIPS pipeline with branch delay slot. Holds the fetch PC and issues instruction-memory requests over a req/gnt/rvalid handshake, one outstanding request at most.
- Owns the IF/ID pipeline register that feeds the decoder and next-PC logic.
- Consumes the D-stage redirect (jump/branch target) and applies it after the delay-slot fetch.

Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset.
- NOP, 32'h0000_0000, instruction word loaded into IF/ID for bubbles.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- stall_i  in  1  hazard unit: hold IF/ID and ignore redirect_i.
- redirect_i  in  1  D-stage instruction is a taken jump/branch; meaningful only when valid_d_o=1 and stall_i=0.
- target_i  in  32  redirect target (jr/j/jal/beq).
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  fetch address, word aligned.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  read data valid; at least 1 cycle after gnt.
- imem_rdata_i  in  32  instruction word.
- ir_d_o  out  32  IF/ID instruction.
- pc_d_o  out  32  IF/ID PC.
- pc4_d_o  out  32  IF/ID PC+4.
- valid_d_o  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset values: fetch_pc=RESET_PC; state=S_REQ; ir_d_o=NOP; pc_d_o=0; pc4_d_o=4; valid_d_o=0; pending redirect cleared; hold buffer empty. imem_req_o=1 from the first cycle after reset deassertion.
- Reset mid-operation discards any outstanding request. An rvalid arriving in S_REQ or S_HOLD is ignored.
- FSM states:
  - S_REQ: req=1. gnt -> S_WAIT with fetch_pc <= next_seq.
  - S_WAIT: req = rvalid & !stall_i.
    - rvalid & !stall_i: IF/ID <= {rdata, addr, addr+4, valid=1}. If gnt in the same cycle, stay in S_WAIT and advance fetch_pc; else -> S_REQ.
    - rvalid & stall_i: rdata and its address go to the hold buffer -> S_HOLD.
  - S_HOLD: req=0. On !stall_i, IF/ID <= hold buffer -> S_REQ.
- Throughput: with zero-wait memory (gnt same cycle, rvalid next cycle), 1 instruction/cycle in steady state.
- Bubble: IF/ID advances (stall_i=0) with no instruction available -> ir=NOP, valid=0, pc fields unchanged.
- Stall: stall_i=1 holds all IF/ID fields.
- Redirect accepted when redirect_i & valid_d_o & !stall_i. Let ds = pc_d_o+4 (delay slot).
  - If fetch_pc == ds+4 (delay slot already granted): imem_addr_o = target_i combinationally that cycle, and fetch_pc <= target_i (+4 if granted).
  - If fetch_pc == ds (delay slot not yet granted): latch pend_tgt, pend=1. At the delay-slot grant, fetch_pc <= pend_tgt and pend is cleared.
  - The delay slot always executes and is never squashed.
- next_seq = pend ? pend_tgt : fetch_pc+4. 32-bit wrap-around, no overflow flag.
- Simultaneous redirect and stall: redirect ignored; the hazard unit re-presents it.
- imem_addr_o[1:0] is always 2'b00 unless FETCH_ADEL_CHK_EN detects a misaligned target.

Optional Feature:
- FETCH_ADEL_CHK_EN defined:
  - Adds output adel_d_o (1 bit, reset 0).
  - A fetch address with [1:0]!=0 issues no memory request. The stage synthesizes a response the next cycle: ir=NOP, valid=1, adel_d_o=1.
  - fetch_pc then continues at misaligned+4 (or the pending target) so the exception logic can redirect.
- Undefined: no check, no adel_d_o port. Target low bits are forwarded unchanged to imem_addr_o.

Decomposition:
- Package fetch_pkg: state encoding (S_REQ, S_WAIT, S_HOLD), RESET_PC and NOP defaults, IF/ID field widths.
- Sub-module if_id_reg: IF/ID register with load/hold/bubble controls. The FSM, fetch_pc, pending-redirect and hold buffer stay in fetch_stage.

Test Plan:
- Zero-wait memory, no stalls, after reset -> addresses 0x3000, 0x3004, 0x3008 on consecutive cycles; valid_d_o=1 from the 3rd cycle; pc4_d_o = pc_d_o+4.
- rvalid for 0x3004 while stall_i=1 for 3 cycles -> IF/ID holds 0x3000, no req during S_HOLD; 0x3004 reaches IF/ID the cycle after stall drops; no instruction lost or duplicated.
- Branch at 0x3008 in D with delay slot granted, target_i=0x3100 -> next imem_addr_o=0x3100; IF/ID sequence 0x3008, 0x300C, 0x3100.
- Same branch, memory delays gnt for 0x300C by 4 cycles -> pend set; requests 0x300C then 0x3100; bubbles (valid=0) in D between.
- redirect_i=1 with stall_i=1 -> fetch_pc unchanged; re-presented with stall_i=0 -> applied as above.
- reset asserted while in S_WAIT, late rvalid after release -> ignored; first IF/ID instruction is from 0x3000.
